// File: rtl/me_search_ctrl.sv
// Motion-estimation search sequencer: fetches SEARCH_ROWS reference rows, tags them through
// the PE-array latency, feeds masked SADs to the min-SAD post-processor and latches the result.
module me_search_ctrl #(
    parameter int SAD_BIT_WIDTH = 14,
    parameter int SEARCH_ROWS   = 32,
    parameter int PIPE_LATENCY  = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     ref_row_req,
    output logic [4:0]               ref_row_addr,
    input  logic                     ref_row_ready,
    input  logic [SAD_BIT_WIDTH-1:0] pe_sad_in,
    input  logic [3:0]               pe_col_in,
    output logic                     pp_en,
    output logic [SAD_BIT_WIDTH-1:0] pp_msad_interim,
    output logic [3:0]               pp_index_interim,
    output logic [4:0]               pp_current_row,
    input  logic [SAD_BIT_WIDTH-1:0] pp_msad,
    input  logic [4:0]               pp_msad_col,
    input  logic [4:0]               pp_msad_row,
    output logic                     result_valid,
    output logic [SAD_BIT_WIDTH-1:0] result_sad,
    output logic [4:0]               result_col,
    output logic [4:0]               result_row
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_SETTLE = 3'd4,
        ST_REPORT = 3'd5
    } state_t;

    localparam logic [4:0] LAST_ROW   = 5'(SEARCH_ROWS - 1);
    localparam int         LAST_STAGE = PIPE_LATENCY - 1;

    state_t                   state_q, state_d;
    logic [4:0]               row_q, row_d;
    logic [PIPE_LATENCY-1:0]  vld_q, vld_d;
    logic [4:0]               tag_q [PIPE_LATENCY];
    logic [4:0]               tag_d [PIPE_LATENCY];
    logic                     result_valid_q, result_valid_d;
    logic [SAD_BIT_WIDTH-1:0] result_sad_q, result_sad_d;
    logic [4:0]               result_col_q, result_col_d;
    logic [4:0]               result_row_q, result_row_d;
    logic                     busy_s;
    logic                     accept_s;
    logic                     pipe_empty_s;

    assign busy_s       = (state_q != ST_IDLE);
    assign accept_s     = (state_q == ST_ISSUE) && ref_row_ready;
    assign pipe_empty_s = (vld_q == {PIPE_LATENCY{1'b0}});

    // Sequencer: next state, row counter, handshake/enable decode and result capture
    always_comb begin
        state_d        = state_q;
        row_d          = row_q;
        result_valid_d = result_valid_q;
        result_sad_d   = result_sad_q;
        result_col_d   = result_col_q;
        result_row_d   = result_row_q;
        pp_en          = 1'b0;
        ref_row_req    = 1'b0;
        done           = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d        = ST_CLEAR;
                    result_valid_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                row_d   = 5'd0;
                state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                pp_en       = 1'b1;
                ref_row_req = 1'b1;
                if (accept_s) begin
                    row_d = row_q + 5'd1;
                    if (row_q == LAST_ROW) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end else begin
                    row_d = row_q;
                end
            end
            ST_DRAIN: begin
                pp_en = 1'b1;
                if (pipe_empty_s) begin
                    state_d = ST_SETTLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_SETTLE: begin
                // Post-processor has absorbed the final row by now; capture so done and result align
                pp_en          = 1'b1;
                state_d        = ST_REPORT;
                result_valid_d = 1'b1;
                result_sad_d   = pp_msad;
                result_col_d   = pp_msad_col;
                result_row_d   = pp_msad_row;
            end
            ST_REPORT: begin
                pp_en   = 1'b1;
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Row-tag delay line mirroring the PE-array latency
    always_comb begin
        vld_d = vld_q;
        tag_d = tag_q;
        if (busy_s) begin
            vld_d[0] = accept_s;
            tag_d[0] = row_q;
            for (int i = 1; i < PIPE_LATENCY; i++) begin
                vld_d[i] = vld_q[i-1];
                tag_d[i] = tag_q[i-1];
            end
        end else begin
            vld_d = {PIPE_LATENCY{1'b0}};
            for (int i = 0; i < PIPE_LATENCY; i++) begin
                tag_d[i] = 5'd0;
            end
        end
    end

    // Empty slots present all-ones so the post-processor's strict compare never fires
    always_comb begin
        if (vld_q[LAST_STAGE]) begin
            pp_msad_interim  = pe_sad_in;
            pp_index_interim = pe_col_in;
            pp_current_row   = tag_q[LAST_STAGE];
        end else begin
            pp_msad_interim  = {SAD_BIT_WIDTH{1'b1}};
            pp_index_interim = 4'd0;
            pp_current_row   = 5'd0;
        end
    end

    // State, counter, delay line and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            row_q          <= 5'd0;
            vld_q          <= {PIPE_LATENCY{1'b0}};
            for (int i = 0; i < PIPE_LATENCY; i++) begin
                tag_q[i] <= 5'd0;
            end
            result_valid_q <= 1'b0;
            result_sad_q   <= {SAD_BIT_WIDTH{1'b0}};
            result_col_q   <= 5'd0;
            result_row_q   <= 5'd0;
        end else begin
            state_q        <= state_d;
            row_q          <= row_d;
            vld_q          <= vld_d;
            tag_q          <= tag_d;
            result_valid_q <= result_valid_d;
            result_sad_q   <= result_sad_d;
            result_col_q   <= result_col_d;
            result_row_q   <= result_row_d;
        end
    end

    assign busy         = busy_s;
    assign ref_row_addr = row_q;
    assign result_valid = result_valid_q;
    assign result_sad   = result_sad_q;
    assign result_col   = result_col_q;
    assign result_row   = result_row_q;

endmodule
